ser_frame_router: RTL and testbench

- Upstream framing stage for the 1-to-4 serial demultiplexer.
- Receives a framed serial stream on serIn, one bit per clock, and decodes a port address and a payload length from the frame header.
- Presents the payload bits on serOut with a one-hot port enable, so the demux steers each bit to the addressed output.
- Flags a good or bad stop bit for each frame.

---
 rtl/ser_frame_router_if.sv | 31 +++
 rtl/ser_frame_router.sv | 156 +++++++++++++++
 tb/tb_ser_frame_router.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ser_frame_router_if.sv
// Serial framing bus between the frame router and its neighbours.
// The slave side is the router: it consumes serIn and drives the payload,
// port steer and frame status signals toward the demux.
interface ser_frame_router_if #(
  parameter int ADDR_W = 2
);
  logic                   serIn;
  logic                   serOut;
  logic [2**ADDR_W-1:0]   portEn;
  logic                   busy;
  logic                   frameDone;
  logic                   frameErr;

  modport master (
    output serIn,
    input  serOut,
    input  portEn,
    input  busy,
    input  frameDone,
    input  frameErr
  );

  modport slave (
    input  serIn,
    output serOut,
    output portEn,
    output busy,
    output frameDone,
    output frameErr
  );
endinterface

// File: rtl/ser_frame_router.sv
// Serial frame router: decodes start / address / count / payload / stop
// from a one-bit-per-clock stream and steers each payload bit to the
// addressed demux port with a one-hot enable. All outputs are registered.
module ser_frame_router #(
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  ser_frame_router_if.slave bus
);

  localparam int NPORT = 2**ADDR_W;
  localparam int MAXF  = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
  localparam int BC_W  = $clog2(MAXF + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [BC_W-1:0]    bit_q, bit_d;
  logic               ser_out_q, ser_out_d;
  logic [NPORT-1:0]   port_en_q, port_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Header fields are shifted in MSB first; these are the post-shift values.
  logic [ADDR_W-1:0]  addr_shift_s;
  logic [CNT_W-1:0]   cnt_shift_s;

  // Shift helpers for assembling header fields from the serial line.
  always_comb begin
    addr_shift_s = (addr_q << 1) | ADDR_W'(bus.serIn);
    cnt_shift_s  = (cnt_q << 1) | CNT_W'(bus.serIn);
  end

  // Next-state and next-output decode for the framing FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    bit_d     = bit_q;
    ser_out_d = 1'b1;
    port_en_d = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.serIn == 1'b0) begin
          state_d = ADDR;
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      ADDR: begin
        addr_d = addr_shift_s;
        if (bit_q == BC_W'(ADDR_W - 1)) begin
          state_d = COUNT;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BC_W'(1);
        end
      end

      COUNT: begin
        cnt_d = cnt_shift_s;
        if (bit_q == BC_W'(CNT_W - 1)) begin
          bit_d = '0;
          // A zero-length frame goes straight to the stop bit.
          if (cnt_shift_s == '0) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
            rem_d   = cnt_shift_s;
          end
        end else begin
          bit_d = bit_q + BC_W'(1);
        end
      end

      DATA: begin
        ser_out_d = bus.serIn;
        port_en_d = NPORT'(1'b1) << addr_q;
        rem_d     = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = STOP;
        end else begin
          state_d = DATA;
        end
      end

      STOP: begin
        // The stop bit is consumed here whatever its value; no re-use as start.
        state_d = IDLE;
        if (bus.serIn == 1'b1) begin
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; async reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      bit_q     <= '0;
      ser_out_q <= 1'b1;
      port_en_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      bit_q     <= bit_d;
      ser_out_q <= ser_out_d;
      port_en_q <= port_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.serOut    = ser_out_q;
  assign bus.portEn    = port_en_q;
  assign bus.busy      = busy_q;
  assign bus.frameDone = done_q;
  assign bus.frameErr  = err_q;

endmodule

// File: tb/tb_ser_frame_router.sv
// Directed bench for ser_frame_router. Each cycle's outputs are packed as
// {portEn[3:0], serOut, busy, frameDone, frameErr} and compared against an
// expectation built from the frame fields.
module tb_ser_frame_router;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  ser_frame_router_if #(.ADDR_W(2)) bus ();

  ser_frame_router #(.ADDR_W(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs_now();
    return {bus.portEn, bus.serOut, bus.busy, bus.frameDone, bus.frameErr};
  endfunction

  // Drive n bits (bits[n-1] first); record outputs #1 after each sampling edge.
  task automatic drive(input logic [63:0] bits, input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      bus.serIn = bits[n-1-i];
      @(posedge clk);
      #1;
      obs_q.push_back(obs_now());
    end
    bus.serIn = 1'b1;
  endtask

  // Expected per-edge outputs for a whole frame, starting at its start bit.
  task automatic exp_frame(input int addr, input int cnt, input logic [15:0] data,
                           input logic stop_bit);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h0C);
    for (int j = 0; j < cnt; j++)
      exp_q.push_back({4'(1 << addr), data[cnt-1-j], 1'b1, 2'b00});
    exp_q.push_back({4'b0000, 1'b1, 1'b0, stop_bit, ~stop_bit});
  endtask

  task automatic exp_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'h08);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.serIn = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_now() !== 8'h08) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", obs_now(), 8'h08);
    end
    #9;
    checks++;
    if (obs_now() !== 8'h08) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", obs_now(), 8'h08);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_idle();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    drive(64'hFFFFF, 20);
    exp_q.delete();
    exp_idle(20);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL idle[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_normal();
    drive({1'b0, 2'b10, 4'b0011, 3'b101, 1'b1, 1'b1}, 12);
    exp_q.delete();
    exp_frame(2, 3, 16'b101, 1'b1);
    exp_idle(1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL normal[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_empty_and_full();
    drive({1'b0, 2'b01, 4'b0000, 1'b1, 1'b1}, 9);
    exp_q.delete();
    exp_frame(1, 0, 16'h0000, 1'b1);
    exp_idle(1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL empty[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    drive({1'b0, 2'b11, 4'b1111, 15'b101010101010101, 1'b1, 1'b1}, 24);
    exp_q.delete();
    exp_frame(3, 15, 16'h5555, 1'b1);
    exp_idle(1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stop_err();
    drive({1'b0, 2'b00, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1}, 11);
    exp_q.delete();
    exp_frame(0, 1, 16'h0001, 1'b0);
    exp_idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stop_err[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive({1'b0, 2'b00, 4'b0010, 2'b11, 1'b1,
           1'b0, 2'b11, 4'b0001, 1'b0, 1'b1, 1'b1}, 20);
    exp_q.delete();
    exp_frame(0, 2, 16'b11, 1'b1);
    exp_frame(3, 1, 16'b0, 1'b1);
    exp_idle(1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_data();
    // Header plus two of five payload bits, then an asynchronous reset.
    drive({1'b0, 2'b01, 4'b0101, 2'b11}, 9);
    bus.serIn = 1'b0;
    exp_q.delete();
    exp_frame(1, 5, 16'b11010, 1'b1);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_pre[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_now() !== 8'h08) begin
      errors++;
      $display("FAIL mid_reset: got %b expected %b", obs_now(), 8'h08);
    end
    bus.serIn = 1'b1;
    #8 rst = 1'b0;
    drive({3'b111, 1'b0, 2'b01, 4'b0101, 5'b10110, 1'b1, 1'b1}, 17);
    exp_q.delete();
    exp_idle(3);
    exp_frame(1, 5, 16'b10110, 1'b1);
    exp_idle(1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_post[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_idle();
    test_normal();
    test_empty_and_full();
    test_stop_err();
    test_back_to_back();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
